// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared definitions for the set-associative instruction
//               cache: FSM state encodings and address-field width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  // Explicit state encodings; the enum below is built on these values.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    FLUSH = ST_FLUSH
  } state_e;

  // Tag occupies whatever is left of the address above index and offset.
  function automatic int tag_width(input int s_offset, input int s_index);
    return ADDR_W - s_offset - s_index;
  endfunction

  function automatic int index_msb(input int s_offset, input int s_index);
    return s_offset + s_index - 1;
  endfunction

  function automatic int tag_lsb(input int s_offset, input int s_index);
    return s_offset + s_index;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_assoc_plru_tree.sv
`default_nettype none
// ============================================================================
// Module      : plru_tree
// Description : Tree pseudo-LRU for one set. Node i has children 2i+1 (left)
//               and 2i+2 (right); a node bit of 0 steers the victim search
//               left, 1 steers it right. An access flips every node on its
//               path to point away from the accessed way.
// Ports       : tree_bits   - current PLRU bits of the set
//               access_way  - way being hit or filled
//               victim      - way the tree currently selects for eviction
//               tree_next   - PLRU bits after recording access_way
// Revision    : 1.0 - initial release
// ============================================================================
module plru_tree #(
  parameter int NUM_WAYS = 4
) (
  input  logic [NUM_WAYS-2:0]         tree_bits,
  input  logic [$clog2(NUM_WAYS)-1:0] access_way,
  output logic [$clog2(NUM_WAYS)-1:0] victim,
  output logic [NUM_WAYS-2:0]         tree_next
);

  localparam int WAY_W = $clog2(NUM_WAYS);

  // Walk from the root, collecting the steering bits MSB first.
  always_comb begin
    int node;
    node   = 0;
    victim = '0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      victim = (victim << 1) | WAY_W'(tree_bits[node[WAY_W-1:0]]);
      node   = 2 * node + 1 + int'(tree_bits[node[WAY_W-1:0]]);
    end
  end

  // Follow the accessed way's path, pointing each node the other way.
  always_comb begin
    int                 node;
    logic [WAY_W-1:0]   way_sh;
    logic               dir;
    node      = 0;
    way_sh    = access_way;
    dir       = 1'b0;
    tree_next = tree_bits;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      dir                           = way_sh[WAY_W-1];
      way_sh                        = way_sh << 1;
      tree_next[node[WAY_W-1:0]]    = ~dir;
      node                          = 2 * node + 1 + int'(dir);
    end
  end

endmodule
`default_nettype wire

// File: rtl/icache_assoc.sv
`default_nettype none
// ============================================================================
// Module      : icache_assoc
// Description : Read-only set-associative instruction cache with zero-cycle
//               hit latency, single-line fill on miss, tree-PLRU replacement
//               and a one-cycle whole-cache flush.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               mem_address/read  - CPU fetch request (held until mem_resp)
//               mem_rdata256/resp - hit line and one-cycle response strobe
//               flush             - single-cycle invalidate-all request
//               pmem_*            - line fill interface to backing memory
// Revision    : 1.0 - initial release
// ============================================================================
module icache_assoc
  import icache_pkg::*;
#(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int NUM_WAYS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic              mem_read,
  output logic [LINE_W-1:0] mem_rdata256,
  output logic              mem_resp,
  input  logic              flush,
  output logic [ADDR_W-1:0] pmem_address,
  output logic              pmem_read,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int TAG_W   = tag_width(S_OFFSET, S_INDEX);
  localparam int IDX_MSB = index_msb(S_OFFSET, S_INDEX);
  localparam int TAG_LSB = tag_lsb(S_OFFSET, S_INDEX);
  localparam int SETS    = 1 << S_INDEX;
  localparam int WAY_W   = $clog2(NUM_WAYS);

  // Storage
  logic [LINE_W-1:0]   r_data  [SETS][NUM_WAYS];
  logic [TAG_W-1:0]    r_tag   [SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] r_valid [SETS];
  logic [NUM_WAYS-2:0] r_plru  [SETS];

  // Control
  state_e              r_state;
  logic                r_flush_pend;
  logic [TAG_W-1:0]    r_fill_tag;
  logic [S_INDEX-1:0]  r_fill_index;

  logic [TAG_W-1:0]    w_tag;
  logic [S_INDEX-1:0]  w_index;
  logic [NUM_WAYS-1:0] w_hit_vec;
  logic                w_hit;
  logic [WAY_W-1:0]    w_hit_way;
  logic [NUM_WAYS-1:0] w_fill_valid;
  logic [WAY_W-1:0]    w_first_inv;
  logic [WAY_W-1:0]    w_victim;
  logic [WAY_W-1:0]    w_plru_victim;
  logic [S_INDEX-1:0]  w_plru_set;
  logic [WAY_W-1:0]    w_acc_way;
  logic [NUM_WAYS-2:0] w_plru_next;
  logic                w_hit_resp;
  logic                w_fill;
  logic                w_unused_offset;

  assign w_tag           = mem_address[ADDR_W-1:TAG_LSB];
  assign w_index         = mem_address[IDX_MSB:S_OFFSET];
  assign w_unused_offset = ^mem_address[S_OFFSET-1:0];

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_hit
    assign w_hit_vec[g] = r_valid[w_index][g] && (r_tag[w_index][g] == w_tag);
  end

  assign w_hit = |w_hit_vec;

  always_comb begin
    w_hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
    end
  end

  // Victim: lowest-numbered invalid way of the fill set, else the PLRU way.
  assign w_fill_valid = r_valid[r_fill_index];

  always_comb begin
    w_first_inv = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!w_fill_valid[w]) w_first_inv = WAY_W'(w);
    end
  end

  assign w_victim = (&w_fill_valid) ? w_plru_victim : w_first_inv;

  // One PLRU tree serves both the fill set (in FETCH) and the hit set.
  assign w_plru_set = (r_state == FETCH) ? r_fill_index : w_index;
  assign w_acc_way  = (r_state == FETCH) ? w_victim : w_hit_way;

  plru_tree #(
    .NUM_WAYS (NUM_WAYS)
  ) u_plru (
    .tree_bits  (r_plru[w_plru_set]),
    .access_way (w_acc_way),
    .victim     (w_plru_victim),
    .tree_next  (w_plru_next)
  );

  // Outputs are gated with rst so they read zero throughout reset.
  assign w_hit_resp   = (r_state == IDLE) && mem_read && w_hit && !flush && !rst;
  assign w_fill       = (r_state == FETCH) && pmem_resp && !rst;
  assign mem_resp     = w_hit_resp;
  assign mem_rdata256 = w_hit_resp ? r_data[w_index][w_hit_way] : '0;
  assign pmem_read    = (r_state == FETCH) && !rst;
  assign pmem_address = pmem_read ? {r_fill_tag, r_fill_index, {S_OFFSET{1'b0}}} : '0;

  // Line payload and tags need no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[r_fill_index][w_victim] <= pmem_rdata;
      r_tag[r_fill_index][w_victim]  <= r_fill_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_flush_pend <= 1'b0;
      r_fill_tag   <= '0;
      r_fill_index <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (flush) begin
            r_state <= FLUSH;
          end else if (mem_read && !w_hit) begin
            r_state      <= FETCH;
            r_fill_tag   <= w_tag;
            r_fill_index <= w_index;
          end else if (w_hit_resp) begin
            r_plru[w_index] <= w_plru_next;
          end
        end
        FETCH: begin
          if (flush) r_flush_pend <= 1'b1;
          if (pmem_resp) begin
            r_valid[r_fill_index][w_victim] <= 1'b1;
            r_plru[r_fill_index]            <= w_plru_next;
            r_flush_pend                    <= 1'b0;
            r_state <= (r_flush_pend || flush) ? FLUSH : IDLE;
          end
        end
        FLUSH: begin
          for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_plru[s]  <= '0;
          end
          r_flush_pend <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A line may live in at most one way of its set.
  a_single_hit : assert property (@(posedge clk) disable iff (rst)
    (r_state == IDLE && mem_read) |-> $onehot0(w_hit_vec));

endmodule
`default_nettype wire

// File: tb/tb_icache_assoc.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_assoc
// Description : Directed self-checking bench for icache_assoc (4-way,
//               8 sets, 32-byte lines).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_assoc;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic [255:0] mem_rdata256;
  logic         mem_resp;
  logic         flush;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  icache_assoc #(
    .S_OFFSET (5),
    .S_INDEX  (3),
    .NUM_WAYS (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_rdata256 (mem_rdata256),
    .mem_resp     (mem_resp),
    .flush        (flush),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        hit;
  } vec_t;

  vec_t vecs [0:15];

  function automatic logic [255:0] line_of(input logic [31:0] addr);
    return {8{addr ^ 32'h5EED_0000}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_mem_resp"},  mem_resp,     256'd0);
    chk({nm, "_rdata"},     mem_rdata256, 256'd0);
    chk({nm, "_pmem_read"}, pmem_read,    256'd0);
    chk({nm, "_pmem_addr"}, pmem_address, 256'd0);
  endtask

  task automatic do_reset(input logic with_read);
    rst       = 1'b1;
    mem_read  = with_read;
    flush     = 1'b0;
    pmem_resp = 1'b0;
    #5;
    chk_idle_outputs("in_reset");
    cyc();
    rst      = 1'b0;
    mem_read = 1'b0;
    #5;
    chk_idle_outputs("after_reset");
    cyc();
  endtask

  // Called at a drive point while the DUT is in FETCH for addr.
  task automatic finish_fill(input logic [31:0] addr, input logic [255:0] line);
    #5;
    chk("fill_pmem_read", pmem_read, 256'd1);
    chk("fill_pmem_addr", pmem_address, {224'd0, addr & 32'hFFFF_FFE0});
    cyc();
    pmem_rdata = line;
    pmem_resp  = 1'b1;
    cyc();
    pmem_resp  = 1'b0;
    pmem_rdata = {8{32'hDEAD_BEEF}};
    #5;
    chk("retry_resp", mem_resp, 256'd1);
    chk("retry_data", mem_rdata256, line);
    cyc();
    mem_read = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic hit, input logic [255:0] line);
    mem_address = addr;
    mem_read    = 1'b1;
    #5;
    if (hit) begin
      chk("hit_resp", mem_resp, 256'd1);
      chk("hit_data", mem_rdata256, line);
      chk("hit_no_pmem_read", pmem_read, 256'd0);
      cyc();
      mem_read = 1'b0;
    end else begin
      chk("miss_resp", mem_resp, 256'd0);
      chk("miss_rdata_zero", mem_rdata256, 256'd0);
      cyc();
      finish_fill(addr, line);
    end
  endtask

  initial begin
    rst         = 1'b1;
    mem_read    = 1'b1;
    mem_address = 32'h0000_1040;
    flush       = 1'b0;
    pmem_resp   = 1'b0;
    pmem_rdata  = {8{32'hDEAD_BEEF}};

    vecs[0]  = '{32'h0000_0140, 1'b0};
    vecs[1]  = '{32'h0000_0240, 1'b0};
    vecs[2]  = '{32'h0000_0340, 1'b0};
    vecs[3]  = '{32'h0000_0440, 1'b0};
    vecs[4]  = '{32'h0000_0140, 1'b1};
    vecs[5]  = '{32'h0000_0240, 1'b1};
    vecs[6]  = '{32'h0000_0340, 1'b1};
    vecs[7]  = '{32'h0000_0440, 1'b1};
    vecs[8]  = '{32'h0000_0140, 1'b1};
    vecs[9]  = '{32'h0000_0340, 1'b1};
    vecs[10] = '{32'h0000_0540, 1'b0};  // evicts way 1 (tag 2)
    vecs[11] = '{32'h0000_0240, 1'b0};  // evicts way 3 (tag 4)
    vecs[12] = '{32'h0000_0140, 1'b1};
    vecs[13] = '{32'h0000_0340, 1'b1};
    vecs[14] = '{32'h0000_0540, 1'b1};
    vecs[15] = '{32'h0000_0440, 1'b0};

    cyc();
    do_reset(1'b1);

    // Cold miss with an all-A5 line.
    do_read(32'h0000_1040, 1'b0, {32{8'hA5}});

    // Fill order and PLRU replacement in set 2.
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) begin
      do_read(vecs[i].addr, vecs[i].hit, line_of(vecs[i].addr));
    end

    // Flush pulse during FETCH: fill completes, then cache is flushed.
    do_reset(1'b0);
    mem_address = 32'h0000_2040;
    mem_read    = 1'b1;
    cyc();
    flush = 1'b1;
    #5;
    chk("fflush_pmem_read", pmem_read, 256'd1);
    cyc();
    flush = 1'b0;
    #5;
    chk("fflush_still_fetch", pmem_read, 256'd1);
    cyc();
    pmem_rdata = line_of(32'h0000_2040);
    pmem_resp  = 1'b1;
    cyc();
    pmem_resp  = 1'b0;
    #5;
    chk("fflush_flush_no_resp", mem_resp, 256'd0);
    chk("fflush_flush_no_pmem", pmem_read, 256'd0);
    cyc();
    #5;
    chk("fflush_reread_miss", mem_resp, 256'd0);
    cyc();
    finish_fill(32'h0000_2040, line_of(32'h0000_2040));

    // Flush and mem_read in the same IDLE cycle.
    do_reset(1'b0);
    do_read(32'h0000_3040, 1'b0, line_of(32'h0000_3040));
    do_read(32'h0000_3040, 1'b1, line_of(32'h0000_3040));
    mem_address = 32'h0000_3040;
    mem_read    = 1'b1;
    flush       = 1'b1;
    #5;
    chk("iflush_no_resp", mem_resp, 256'd0);
    chk("iflush_rdata_zero", mem_rdata256, 256'd0);
    cyc();
    flush = 1'b0;
    #5;
    chk("iflush_flush_no_resp", mem_resp, 256'd0);
    cyc();
    do_read(32'h0000_3040, 1'b0, line_of(32'h0000_3040) ^ {8{32'h1}});

    // Reset in the middle of a fill.
    do_reset(1'b0);
    mem_address = 32'h0000_4040;
    mem_read    = 1'b1;
    cyc();
    #5;
    chk("rfetch_pmem_read", pmem_read, 256'd1);
    cyc();
    rst = 1'b1;
    #5;
    chk("rfetch_in_reset_pmem", pmem_read, 256'd0);
    cyc();
    rst      = 1'b0;
    mem_read = 1'b0;
    #5;
    chk("rfetch_after_pmem", pmem_read, 256'd0);
    cyc();
    pmem_rdata = line_of(32'h0000_4040);
    pmem_resp  = 1'b1;
    #5;
    chk("stray_resp_no_pmem", pmem_read, 256'd0);
    chk("stray_resp_no_memresp", mem_resp, 256'd0);
    cyc();
    pmem_resp = 1'b0;
    do_read(32'h0000_4040, 1'b0, {8{32'h0BAD_F00D}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
